uart_mem_loader: RTL and testbench
==================================

Name: uart_mem_loader

Overview:
- Upstream stage of the processor core: receives a program/image over UART and writes it into processor memory.
- Deserialises 8N1 bytes from `rx` and pairs them, high byte first, into 16-bit words.
- Writes each word to consecutive memory addresses starting at 0.
- Asserts `done` when the programmed number of words has been stored, so the core may start fetching.

Parameters:
- CLKS_PER_BIT, 868: clk cycles per UART bit (100 MHz / 115200); legal range 4..65535.
- NUM_WORDS, 256: 16-bit words to load before `done`; legal range 1..65536.
- ADDR_W, 16: width of `mem_addr`.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- receive  in  1  start-load request; rising edge sampled.
- rx  in  1  UART serial input, asynchronous, idle high.
- mem_wr  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  write address (word index).
- mem_wdata  out  16  write data {first_byte, second_byte}.
- busy  out  1  high while a load is in progress.
- done  out  1  high after a complete load; held until next start or rst.
- frame_err  out  1  sticky: a stop bit sampled low during the current load.
- rx_LED  out  1  equals busy.

Behaviour:
- Reset (rst=1 at a clk edge), in effect the next cycle:
  - mem_wr=0, mem_addr=0, mem_wdata=0, busy=0, done=0, frame_err=0.
  - rx synchroniser = 1; all counters 0; both FSMs in their idle state.
  - A reset mid-load aborts the load; already-written words are not rolled back.
- rx input: two-flop synchroniser; all internal logic uses the synchronised signal (2-cycle input latency).
- Load control FSM, states L_IDLE, L_LOAD:
  - L_IDLE: a `receive` rising edge (registered previous value) moves to L_LOAD and, in the same transition, sets busy=1, clears done and frame_err, resets the word counter and the byte-phase flag.
  - L_LOAD: the UART FSM runs. When the word counter reaches NUM_WORDS after a write, go to L_IDLE with busy=0 and done=1, asserted the cycle after the last mem_wr.
  - `receive` edges during L_LOAD are ignored.
- UART RX FSM, states U_IDLE, U_START, U_DATA, U_STOP; active only in L_LOAD:
  - U_IDLE: synchronised rx=0 → U_START, baud counter cleared.
  - U_START: wait CLKS_PER_BIT/2 cycles (integer division), then sample. Low → U_DATA. High (glitch) → U_IDLE with no byte.
  - U_DATA: sample every CLKS_PER_BIT cycles. 8 bits, LSB first, shifted into the byte register. After bit 7 → U_STOP.
  - U_STOP: sample after CLKS_PER_BIT cycles.
    - High: byte valid.
    - Low: set frame_err, discard the byte, leave the byte-phase flag unchanged.
    - Either way, return to U_IDLE.
- Byte pairing and write:
  - First valid byte latches into the high byte.
  - Second valid byte forms the word. On the next cycle: mem_wr=1 for exactly one cycle, mem_addr = word counter, mem_wdata = {hi, lo}.
  - The word counter increments after the write; mem_addr holds its last value while mem_wr=0.
- Boundaries:
  - Word counter width is ADDR_W+1, so NUM_WORDS=65536 terminates without wrap.
  - A trailing odd byte at the end of a stream stays pending; it is never written.
  - Bytes arriving in L_IDLE are ignored; the UART FSM is held in U_IDLE.
  - A `receive` edge on the same cycle as the final write is ignored.
  - A stop bit and the next start bit closer than half a bit are not supported; senders use ≥1 stop bit.

Decomposition:
- Shared package:
  - UART state encodings (U_IDLE..U_STOP).
  - Load state encodings.
  - Default CLKS_PER_BIT constant, shared with the matching UART transmitter.
- Sub-module `uart_rx_byte`:
  - Contains the synchroniser, baud counter, UART FSM and shift register.
  - Outputs a byte_valid pulse, byte[7:0] and frame_err_pulse.
  - Reused by the transmitter loopback bench.
- `uart_mem_loader` holds the load FSM, byte pairing and address counter.

Test Plan:
- Bench settings: CLKS_PER_BIT=16, NUM_WORDS=2.
- Normal load: receive pulse, send bytes 0x12,0x34,0xAB,0xCD → writes (addr 0, 0x1234) then (addr 1, 0xABCD). done=1 one cycle after the second mem_wr; busy=0; frame_err=0.
- Glitch rejection: rx low for 4 cycles then high, then a normal 4-byte stream → no spurious byte; same two writes as the normal load.
- Framing error: byte 0x55 sent with stop bit 0, then 0x12,0x34,0x56,0x78 → frame_err=1; writes (0, 0x1234), (1, 0x5678).
- Reset mid-load: rst pulsed after the first word is written → all outputs 0 the next cycle. Then a new receive plus 4 bytes → writes restart at addr 0.
- Idle ignore and restart: bytes sent before any receive → no mem_wr. After done, a new receive → done=0, busy=1, addr restarts at 0.

Source files
------------

// File: rtl/uart_mem_loader_pkg.sv
// Shared encodings and defaults for the UART memory loader and its matching transmitter.
// No logic here; imported by the loader, the RX byte receiver and the loopback bench.
package uart_mem_loader_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [1:0] {
        U_IDLE,
        U_START,
        U_DATA,
        U_STOP
    } uart_state_t;

    typedef enum logic {
        L_IDLE,
        L_LOAD
    } load_state_t;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 receiver: 2-flop rx synchroniser, mid-bit sampling; one-cycle byte/frame-error pulses at the stop-bit sample.
// No backpressure: a byte pulse is lost unless consumed that cycle; held in U_IDLE while i_en is low.
module uart_rx_byte
    import uart_mem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic       i_rx,
    output logic       o_byte_vld,
    output logic [7:0] o_byte_dat,
    output logic       o_frame_err_pulse
);

    localparam logic [15:0] LP_FULL = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] LP_HALF = 16'(CLKS_PER_BIT / 2 - 1);

    uart_state_t r_state;
    uart_state_t w_state_nxt;
    logic        r_rx_meta;
    logic        r_rx_sync;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        w_cnt_clr;
    logic        w_shift_en;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= U_IDLE;
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
            r_cnt     <= w_cnt_clr ? '0 : r_cnt + 16'd1;
            if (r_state == U_IDLE) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_shift   <= {r_rx_sync, r_shift[7:1]};
                r_bit_idx <= r_bit_idx + 3'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_clr         = 1'b0;
        w_shift_en        = 1'b0;
        o_byte_vld        = 1'b0;
        o_frame_err_pulse = 1'b0;
        case (r_state)
            U_IDLE: begin
                w_cnt_clr = 1'b1;
                if (!r_rx_sync) w_state_nxt = U_START;
            end
            U_START: begin
                // A start bit still high at mid-bit is a glitch, not a frame.
                if (r_cnt == LP_HALF) begin
                    w_cnt_clr   = 1'b1;
                    w_state_nxt = r_rx_sync ? U_IDLE : U_DATA;
                end
            end
            U_DATA: begin
                if (r_cnt == LP_FULL) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_nxt = U_STOP;
                end
            end
            U_STOP: begin
                if (r_cnt == LP_FULL) begin
                    w_cnt_clr         = 1'b1;
                    w_state_nxt       = U_IDLE;
                    o_byte_vld        = r_rx_sync & i_en;
                    o_frame_err_pulse = ~r_rx_sync & i_en;
                end
            end
        endcase
        if (!i_en) w_state_nxt = U_IDLE;
    end

    assign o_byte_dat = r_shift;

endmodule

// File: rtl/uart_mem_loader.sv
// Loads NUM_WORDS big-endian 16-bit words from UART into memory at addresses 0.., then raises done.
// Write strobe lands one cycle after the second byte of a pair; no memory backpressure is honoured.
module uart_mem_loader
    import uart_mem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int NUM_WORDS    = 256,
    parameter int ADDR_W       = 16
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_receive,
    input  logic              i_rx,
    output logic              o_mem_wr,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [15:0]       o_mem_wdata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_frame_err,
    output logic              o_rx_LED
);

    localparam int              CNT_W  = ADDR_W + 1;
    localparam logic [CNT_W-1:0] LP_NUM = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] LP_ONE = CNT_W'(1);

    load_state_t       r_lstate;
    load_state_t       w_lstate_nxt;
    logic              r_receive_prev;
    logic [CNT_W-1:0]  r_word_cnt;
    logic [CNT_W-1:0]  w_cnt_inc;
    logic              r_phase;
    logic [7:0]        r_hi;
    logic              r_mem_wr;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_done;
    logic              r_frame_err;
    logic              w_start;
    logic              w_finish;
    logic              w_rx_en;
    logic              w_byte_vld;
    logic [7:0]        w_byte_dat;
    logic              w_frame_err_pulse;

    assign w_rx_en   = (r_lstate == L_LOAD);
    assign w_cnt_inc = r_word_cnt + LP_ONE;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_rx (
        .i_clk             (i_clk),
        .i_rst             (i_rst),
        .i_en              (w_rx_en),
        .i_rx              (i_rx),
        .o_byte_vld        (w_byte_vld),
        .o_byte_dat        (w_byte_dat),
        .o_frame_err_pulse (w_frame_err_pulse)
    );

    always_comb begin
        w_lstate_nxt = r_lstate;
        w_start      = 1'b0;
        w_finish     = 1'b0;
        case (r_lstate)
            L_IDLE: begin
                if (i_receive && !r_receive_prev) begin
                    w_lstate_nxt = L_LOAD;
                    w_start      = 1'b1;
                end
            end
            L_LOAD: begin
                if (r_mem_wr && (w_cnt_inc == LP_NUM)) begin
                    w_lstate_nxt = L_IDLE;
                    w_finish     = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_lstate       <= L_IDLE;
            r_receive_prev <= 1'b0;
            r_word_cnt     <= '0;
            r_phase        <= 1'b0;
            r_hi           <= '0;
            r_mem_wr       <= 1'b0;
            r_mem_addr     <= '0;
            r_mem_wdata    <= '0;
            r_done         <= 1'b0;
            r_frame_err    <= 1'b0;
        end else begin
            r_lstate       <= w_lstate_nxt;
            r_receive_prev <= i_receive;
            r_mem_wr       <= 1'b0;
            if (w_start) begin
                r_done      <= 1'b0;
                r_frame_err <= 1'b0;
                r_word_cnt  <= '0;
                r_phase     <= 1'b0;
            end
            if (r_lstate == L_LOAD) begin
                if (w_byte_vld) begin
                    if (!r_phase) begin
                        r_hi    <= w_byte_dat;
                        r_phase <= 1'b1;
                    end else begin
                        r_mem_wr    <= 1'b1;
                        r_mem_addr  <= r_word_cnt[ADDR_W-1:0];
                        r_mem_wdata <= {r_hi, w_byte_dat};
                        r_phase     <= 1'b0;
                    end
                end
                // A bad stop bit drops the byte but keeps the pairing phase intact.
                if (w_frame_err_pulse) r_frame_err <= 1'b1;
                if (r_mem_wr) r_word_cnt <= w_cnt_inc;
            end
            if (w_finish) r_done <= 1'b1;
        end
    end

    assign o_mem_wr    = r_mem_wr;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_busy      = w_rx_en;
    assign o_rx_LED    = w_rx_en;
    assign o_done      = r_done;
    assign o_frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_mem_loader.sv
// Scoreboarded bench: a byte-level model queues expected writes, a negedge monitor pops and compares.
module tb_uart_mem_loader;

    localparam int CPB  = 16;
    localparam int NUM  = 2;
    localparam int AW   = 16;

    typedef struct {
        logic [15:0] addr;
        logic [15:0] data;
        bit          last;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          receive = 1'b0;
    logic          rx = 1'b1;
    logic          mem_wr;
    logic [AW-1:0] mem_addr;
    logic [15:0]   mem_wdata;
    logic          busy, done, frame_err, rx_led;

    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    bit   chk_done_pend = 1'b0;

    // Reference model state (byte-stream view of a load)
    bit         m_loading = 1'b0;
    bit         m_done    = 1'b0;
    bit         m_ferr    = 1'b0;
    bit         m_pend    = 1'b0;
    logic [7:0] m_hi      = '0;
    int         m_widx    = 0;

    uart_mem_loader #(
        .CLKS_PER_BIT (CPB),
        .NUM_WORDS    (NUM),
        .ADDR_W       (AW)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_receive   (receive),
        .i_rx        (rx),
        .o_mem_wr    (mem_wr),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_busy      (busy),
        .o_done      (done),
        .o_frame_err (frame_err),
        .o_rx_LED    (rx_led)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_done_pend) begin
            chk_done_pend = 1'b0;
            check("done_after_last_wr", done, 1);
            check("busy_after_last_wr", busy, 0);
        end
        if (mem_wr) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_wr: got addr=%0h data=%0h, expected no write", mem_addr, mem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", mem_addr, mon_e.addr);
                check("wr_data", mem_wdata, mon_e.data);
                if (mon_e.last) chk_done_pend = 1'b1;
            end
        end
    end

    task automatic model_start();
        m_loading = 1'b1;
        m_done    = 1'b0;
        m_ferr    = 1'b0;
        m_pend    = 1'b0;
        m_widx    = 0;
    endtask

    task automatic model_byte(input logic [7:0] d, input bit stop_ok);
        if (!m_loading) return;
        if (!stop_ok) begin
            m_ferr = 1'b1;
        end else if (!m_pend) begin
            m_hi   = d;
            m_pend = 1'b1;
        end else begin
            m_pend = 1'b0;
            exp_q.push_back('{addr: 16'(m_widx), data: {m_hi, d}, last: (m_widx == NUM - 1)});
            m_widx++;
            if (m_widx == NUM) begin
                m_loading = 1'b0;
                m_done    = 1'b1;
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit stop_ok);
        model_byte(d, stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mem_wr"},    mem_wr, 0);
        check({tag, "_mem_addr"},  mem_addr, 0);
        check({tag, "_mem_wdata"}, mem_wdata, 0);
        check({tag, "_busy"},      busy, 0);
        check({tag, "_done"},      done, 0);
        check({tag, "_frame_err"}, frame_err, 0);
        check({tag, "_rx_LED"},    rx_led, 0);
    endtask

    task automatic start_load();
        model_start();
        @(negedge clk);
        receive = 1'b1;
        @(negedge clk);
        receive = 1'b0;
        check("start_busy", busy, 1);
        check("start_done_clr", done, 0);
        check("start_ferr_clr", frame_err, 0);
        check("start_rx_LED", rx_led, 1);
    endtask

    task automatic finish_load(input string tag);
        int i;
        for (i = 0; i < 400 && done !== m_done; i++) @(negedge clk);
        check({tag, "_done"}, done, m_done);
        check({tag, "_busy"}, busy, !m_done);
        check({tag, "_frame_err"}, frame_err, m_ferr);
        check({tag, "_queue_drained"}, exp_q.size(), 0);
    endtask

    initial begin
        logic [7:0] d;
        bit         ok;
        int         guard;

        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_reset_outputs("reset");

        // Bytes before any receive must be ignored
        send_byte(8'h5A, 1'b1);
        send_byte(8'hC3, 1'b1);
        check("idle_busy", busy, 0);

        start_load();
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        finish_load("normal");

        // Restart after done, with a 4-cycle low glitch before the stream
        start_load();
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'hAB, 1'b1);
        send_byte(8'hCD, 1'b1);
        finish_load("glitch");

        start_load();
        send_byte(8'h55, 1'b0);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        finish_load("framing");

        // Reset after the first word lands, then reload from address 0
        start_load();
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
        check("midload_first_wr_seen", exp_q.size(), 0);
        rst = 1'b1;
        m_loading = 1'b0;
        m_done    = 1'b0;
        m_ferr    = 1'b0;
        @(negedge clk);
        check_reset_outputs("midload_rst");
        rst = 1'b0;
        start_load();
        send_byte(8'hDE, 1'b1);
        send_byte(8'hAD, 1'b1);
        send_byte(8'hBE, 1'b1);
        send_byte(8'hEF, 1'b1);
        finish_load("after_rst");

        // Randomised loads with occasional bad stop bits and idle-time noise
        for (int l = 0; l < 6; l++) begin
            if ($urandom_range(0, 1) == 1) send_byte(8'($urandom), 1'b1);
            start_load();
            guard = 0;
            while (m_loading && guard < 30) begin
                d  = 8'($urandom);
                ok = ($urandom_range(0, 4) != 0);
                send_byte(d, ok);
                repeat ($urandom_range(0, 20)) @(negedge clk);
                guard++;
            end
            finish_load("random");
        end

        repeat (20) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
